// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 line assembler: scan codes, decoder states and line geometry.
package ps2_pkg;

  localparam int         LINE_CHARS = 32;
  localparam logic [7:0] FILL_CHAR  = 8'h20;

  localparam logic [7:0] SC_BREAK     = 8'hF0;
  localparam logic [7:0] SC_EXTEND    = 8'hE0;
  localparam logic [7:0] SC_ENTER     = 8'h5A;
  localparam logic [7:0] SC_BACKSPACE = 8'h66;
  localparam logic [7:0] SC_LSHIFT    = 8'h12;
  localparam logic [7:0] SC_RSHIFT    = 8'h59;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BRK,
    ST_EXT,
    ST_EXT_BRK
  } decode_state_t;

  function automatic logic is_shift(input logic [7:0] code);
    return (code == SC_LSHIFT) || (code == SC_RSHIFT);
  endfunction

endpackage

// File: rtl/scancode_to_ascii.sv
// Combinational lookup from a PS/2 set-2 make code to printable ASCII.
module scancode_to_ascii (
  input  logic [7:0] code,
  input  logic       shift,
  output logic [7:0] ascii,
  output logic       valid
);

  always_comb begin
    ascii = 8'h00;
    valid = 1'b1;
    case (code)
      8'h1C: ascii = shift ? "A" : "a";
      8'h32: ascii = shift ? "B" : "b";
      8'h21: ascii = shift ? "C" : "c";
      8'h23: ascii = shift ? "D" : "d";
      8'h24: ascii = shift ? "E" : "e";
      8'h2B: ascii = shift ? "F" : "f";
      8'h34: ascii = shift ? "G" : "g";
      8'h33: ascii = shift ? "H" : "h";
      8'h43: ascii = shift ? "I" : "i";
      8'h3B: ascii = shift ? "J" : "j";
      8'h42: ascii = shift ? "K" : "k";
      8'h4B: ascii = shift ? "L" : "l";
      8'h3A: ascii = shift ? "M" : "m";
      8'h31: ascii = shift ? "N" : "n";
      8'h44: ascii = shift ? "O" : "o";
      8'h4D: ascii = shift ? "P" : "p";
      8'h15: ascii = shift ? "Q" : "q";
      8'h2D: ascii = shift ? "R" : "r";
      8'h1B: ascii = shift ? "S" : "s";
      8'h2C: ascii = shift ? "T" : "t";
      8'h3C: ascii = shift ? "U" : "u";
      8'h2A: ascii = shift ? "V" : "v";
      8'h1D: ascii = shift ? "W" : "w";
      8'h22: ascii = shift ? "X" : "x";
      8'h35: ascii = shift ? "Y" : "y";
      8'h1A: ascii = shift ? "Z" : "z";
      // US-layout shifted symbols on the digit row
      8'h45: ascii = shift ? ")" : "0";
      8'h16: ascii = shift ? "!" : "1";
      8'h1E: ascii = shift ? "@" : "2";
      8'h26: ascii = shift ? "#" : "3";
      8'h25: ascii = shift ? "$" : "4";
      8'h2E: ascii = shift ? "%" : "5";
      8'h36: ascii = shift ? "^" : "6";
      8'h3D: ascii = shift ? "&" : "7";
      8'h3E: ascii = shift ? "*" : "8";
      8'h46: ascii = shift ? "(" : "9";
      8'h29: ascii = " ";
      8'h4E: ascii = shift ? "_" : "-";
      8'h49: ascii = shift ? ">" : ".";
      8'h41: ascii = shift ? "<" : ",";
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/ps2_line_assembler.sv
// Decodes a PS/2 scan-code byte stream into an editable text line, committed on Enter.
module ps2_line_assembler #(
  parameter int         LINE_CHARS = ps2_pkg::LINE_CHARS,
  parameter logic [7:0] FILL_CHAR  = ps2_pkg::FILL_CHAR
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic [7:0]   ps2_key_data,
  input  logic         ps2_key_pressed,
  output logic [255:0] ps2_line_content,
  output logic         ps2_line_ready,
  output logic [255:0] edit_line,
  output logic [5:0]   edit_len,
  output logic         overflow
);

  import ps2_pkg::*;

  localparam logic [5:0]   MAX_LEN   = 6'(LINE_CHARS);
  localparam logic [255:0] FILL_LINE = {32{FILL_CHAR}};

  decode_state_t state;
  logic          shift_held;
  logic [7:0]    map_ascii;
  logic          map_valid;
  logic [5:0]    len_dec;

  assign len_dec = edit_len - 6'd1;

  scancode_to_ascii u_map (
    .code  (ps2_key_data),
    .shift (shift_held),
    .ascii (map_ascii),
    .valid (map_valid)
  );

  // Decoder and line editor share one process so every strobe completes in its own cycle.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state            <= ST_IDLE;
      shift_held       <= 1'b0;
      edit_len         <= 6'd0;
      edit_line        <= FILL_LINE;
      ps2_line_content <= FILL_LINE;
      ps2_line_ready   <= 1'b0;
      overflow         <= 1'b0;
    end else begin
      ps2_line_ready <= 1'b0;
      overflow       <= 1'b0;
      if (ps2_key_pressed) begin
        case (state)
          ST_IDLE: begin
            if (ps2_key_data == SC_BREAK) begin
              state <= ST_BRK;
            end else if (ps2_key_data == SC_EXTEND) begin
              state <= ST_EXT;
            end else if (is_shift(ps2_key_data)) begin
              shift_held <= 1'b1;
            end else if (ps2_key_data == SC_ENTER) begin
              ps2_line_content <= edit_line;
              ps2_line_ready   <= 1'b1;
              edit_line        <= FILL_LINE;
              edit_len         <= 6'd0;
            end else if (ps2_key_data == SC_BACKSPACE) begin
              if (edit_len != 6'd0) begin
                edit_line[{len_dec[4:0], 3'b000} +: 8] <= FILL_CHAR;
                edit_len <= len_dec;
              end
            end else if (map_valid) begin
              if (edit_len < MAX_LEN) begin
                edit_line[{edit_len[4:0], 3'b000} +: 8] <= map_ascii;
                edit_len <= edit_len + 6'd1;
              end else begin
                overflow <= 1'b1;
              end
            end
          end
          ST_BRK: begin
            if (is_shift(ps2_key_data)) shift_held <= 1'b0;
            state <= ST_IDLE;
          end
          ST_EXT: begin
            state <= (ps2_key_data == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_line_assembler.sv
// Randomized bench for ps2_line_assembler against a queue-based model of the typed line.
module tb_ps2_line_assembler;

  logic         clock = 1'b0;
  logic         resetn;
  logic [7:0]   ps2_key_data;
  logic         ps2_key_pressed;
  logic [255:0] ps2_line_content;
  logic         ps2_line_ready;
  logic [255:0] edit_line;
  logic [5:0]   edit_len;
  logic         overflow;

  always #5 clock = ~clock;

  ps2_line_assembler dut (
    .clock            (clock),
    .resetn           (resetn),
    .ps2_key_data     (ps2_key_data),
    .ps2_key_pressed  (ps2_key_pressed),
    .ps2_line_content (ps2_line_content),
    .ps2_line_ready   (ps2_line_ready),
    .edit_line        (edit_line),
    .edit_len         (edit_len),
    .overflow         (overflow)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0]   exp_q[$];
  logic [7:0]   prefix[$];
  bit           exp_shift;
  logic [255:0] exp_content;
  bit           exp_ready;
  bit           exp_overflow;

  logic [7:0] letter_codes[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                   8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                   8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digit_codes[10]  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] other_codes[4]   = '{8'h29, 8'h4E, 8'h49, 8'h41};
  logic [7:0] unmapped_codes[4] = '{8'h75, 8'h05, 8'h76, 8'h0D};
  string      shifted_digits   = ")!@#$%^&*(";

  function automatic logic [255:0] pack_line();
    logic [255:0] v;
    v = {32{8'h20}};
    foreach (exp_q[i]) v[8*i +: 8] = exp_q[i];
    return v;
  endfunction

  function automatic void tb_map(input logic [7:0] code, input bit shift,
                                 output logic [7:0] ch, output bit ok);
    ok = 1'b1;
    ch = 8'h00;
    for (int i = 0; i < 26; i++)
      if (code == letter_codes[i]) begin
        ch = shift ? 8'(8'h41 + i) : 8'(8'h61 + i);
        return;
      end
    for (int i = 0; i < 10; i++)
      if (code == digit_codes[i]) begin
        ch = shift ? shifted_digits[i] : 8'(8'h30 + i);
        return;
      end
    case (code)
      8'h29:   ch = 8'h20;
      8'h4E:   ch = shift ? "_" : "-";
      8'h49:   ch = shift ? ">" : ".";
      8'h41:   ch = shift ? "<" : ",";
      default: ok = 1'b0;
    endcase
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    prefix.delete();
    exp_shift    = 1'b0;
    exp_content  = {32{8'h20}};
    exp_ready    = 1'b0;
    exp_overflow = 1'b0;
  endfunction

  function automatic void model_make(input logic [7:0] d);
    logic [7:0] ch;
    bit         ok;
    if (d == 8'h12 || d == 8'h59) begin
      exp_shift = 1'b1;
    end else if (d == 8'h5A) begin
      exp_content = pack_line();
      exp_ready   = 1'b1;
      exp_q.delete();
    end else if (d == 8'h66) begin
      if (exp_q.size() > 0) void'(exp_q.pop_back());
    end else begin
      tb_map(d, exp_shift, ch, ok);
      if (ok) begin
        if (exp_q.size() < 32) exp_q.push_back(ch);
        else exp_overflow = 1'b1;
      end
    end
  endfunction

  // The pending prefix bytes decide how the next byte is interpreted.
  function automatic void model_byte(input logic [7:0] d);
    if (prefix.size() == 0) begin
      if (d == 8'hF0 || d == 8'hE0) prefix.push_back(d);
      else model_make(d);
    end else if (prefix.size() == 1 && prefix[0] == 8'hF0) begin
      if (d == 8'h12 || d == 8'h59) exp_shift = 1'b0;
      prefix.delete();
    end else if (prefix.size() == 1 && d == 8'hF0) begin
      prefix.push_back(d);
    end else begin
      prefix.delete();
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [255:0] actual, input logic [255:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic check_all();
    checkOutput("edit_line", edit_line, pack_line());
    checkOutput("edit_len", 256'(edit_len), 256'(exp_q.size()));
    checkOutput("content", ps2_line_content, exp_content);
    checkOutput("ready", 256'(ps2_line_ready), 256'(exp_ready));
    checkOutput("overflow", 256'(overflow), 256'(exp_overflow));
  endtask

  // On return the outputs produced by the previous call's byte are visible.
  task automatic applyStimulus(input bit p, input logic [7:0] d);
    @(negedge clock);
    check_all();
    ps2_key_pressed = p;
    ps2_key_data    = d;
    exp_ready       = 1'b0;
    exp_overflow    = 1'b0;
    if (p) model_byte(d);
  endtask

  task automatic hold_reset(input int cycles);
    @(negedge clock);
    check_all();
    resetn          = 1'b0;
    ps2_key_pressed = 1'b0;
    model_reset();
    repeat (cycles) begin
      @(negedge clock);
      check_all();
    end
    resetn = 1'b1;
  endtask

  function automatic logic [7:0] random_byte();
    int r;
    int k;
    r = $urandom_range(0, 99);
    if (r < 55) begin
      k = $urandom_range(0, 39);
      if (k < 26) return letter_codes[k];
      if (k < 36) return digit_codes[k-26];
      return other_codes[k-36];
    end
    if (r < 62) return 8'hF0;
    if (r < 66) return 8'hE0;
    if (r < 71) return ($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59;
    if (r < 73) return 8'h5A;
    if (r < 79) return 8'h66;
    if (r < 88) return unmapped_codes[$urandom_range(0, 3)];
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    resetn          = 1'b0;
    ps2_key_pressed = 1'b0;
    ps2_key_data    = 8'h00;
    model_reset();
    hold_reset(2);

    // "he" typed with releases, then Enter
    applyStimulus(1, 8'h33); applyStimulus(1, 8'hF0); applyStimulus(1, 8'h33);
    applyStimulus(1, 8'h24); applyStimulus(1, 8'hF0); applyStimulus(1, 8'h24);
    applyStimulus(0, 8'h00);
    checkOutput("he_line", 256'(edit_line[15:0]), 256'(16'h6568));
    checkOutput("he_len", 256'(edit_len), 256'd2);
    applyStimulus(1, 8'h5A);
    applyStimulus(0, 8'h00);
    checkOutput("he_content", ps2_line_content, {{30{8'h20}}, 16'h6568});
    checkOutput("he_ready", 256'(ps2_line_ready), 256'd1);
    applyStimulus(0, 8'h00);
    checkOutput("he_ready_drop", 256'(ps2_line_ready), 256'd0);

    // Shift held then released
    applyStimulus(1, 8'h12); applyStimulus(1, 8'h1C); applyStimulus(1, 8'hF0);
    applyStimulus(1, 8'h12); applyStimulus(1, 8'h1C);
    applyStimulus(0, 8'h00);
    checkOutput("Aa_line", 256'(edit_line[15:0]), 256'(16'h6141));
    applyStimulus(1, 8'h5A);

    // Fill the line, overflow, then backspace
    repeat (33) applyStimulus(1, 8'h1C);
    applyStimulus(0, 8'h00);
    checkOutput("full_len", 256'(edit_len), 256'd32);
    checkOutput("ovf_pulse", 256'(overflow), 256'd1);
    applyStimulus(1, 8'h66);
    applyStimulus(0, 8'h00);
    checkOutput("bs_len", 256'(edit_len), 256'd31);
    checkOutput("bs_slot31", 256'(edit_line[255:248]), 256'(8'h20));
    applyStimulus(1, 8'h5A);

    // Backspace on an empty line, then an empty commit
    applyStimulus(1, 8'h66);
    applyStimulus(1, 8'h5A);
    applyStimulus(0, 8'h00);
    checkOutput("empty_content", ps2_line_content, {32{8'h20}});
    checkOutput("empty_ready", 256'(ps2_line_ready), 256'd1);

    // Extended make and release are ignored
    applyStimulus(1, 8'hE0); applyStimulus(1, 8'h75);
    applyStimulus(1, 8'hE0); applyStimulus(1, 8'hF0); applyStimulus(1, 8'h75);
    applyStimulus(1, 8'h1C);
    applyStimulus(0, 8'h00);
    checkOutput("ext_len", 256'(edit_len), 256'd1);

    // Reset after a break prefix discards it
    applyStimulus(1, 8'hF0);
    hold_reset(2);
    applyStimulus(1, 8'h1C);
    applyStimulus(0, 8'h00);
    checkOutput("rst_slot0", 256'(edit_line[7:0]), 256'(8'h61));

    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 999) == 0) hold_reset(2);
      else applyStimulus($urandom_range(0, 9) < 7, random_byte());
    end
    applyStimulus(0, 8'h00);
    applyStimulus(0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
